// File: rtl/datamover_pkg.sv
// Shared datamover definitions: word width and the readout FSM state type.
package datamover_pkg;

  localparam int unsigned DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; the head word always sits in slot 0 so rdata is a plain register.
module sync_fifo2
  import datamover_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] slot0, slot1;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
  end

  // Entries shift toward slot 0 on pop so the head never needs a read mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= wdata;
          else             slot1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= wdata;
          end else begin
            slot0 <= slot1;
            slot1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata = slot0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/bram_stream_dump.sv
// Reads a contiguous BRAM window and streams it out on valid/ready, absorbing the
// 1-cycle read latency with a credit-limited 2-entry return FIFO.
module bram_stream_dump
  import datamover_pkg::*;
#(
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   count,
  output logic [AWIDTH-1:0] daddr,
  output logic              denb,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  dump_state_t       state, state_nxt;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH:0]   reads_left, beats_left;
  logic              inflight;
  logic              accept, issue, pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        occ;
  logic [2:0]        used_slots, slot_limit;

  assign accept  = start && (state != RUN);
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // occupancy + inflight - pop < 2, rearranged to avoid unsigned underflow.
  always_comb begin
    used_slots = {1'b0, occ} + {2'b00, inflight};
    slot_limit = 3'd2 + {2'b00, pop};
    issue      = (state == RUN) && (reads_left != '0) && (used_slots < slot_limit)
                 && (!fifo_full || pop);
  end

  assign daddr = addr;
  assign denb  = issue;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (count != '0) ? RUN : DONE;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (pop && (beats_left == {{AWIDTH{1'b0}}, 1'b1})) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      reads_left <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        addr       <= base_addr;
        reads_left <= count;
        beats_left <= count;
      end else begin
        if (issue) begin
          addr       <= addr + 1'b1;
          reads_left <= reads_left - 1'b1;
        end
        if (pop) beats_left <= beats_left - 1'b1;
      end
    end
  end

  sync_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (din),
    .pop   (pop),
    .rdata (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

endmodule

// File: tb/tb_bram_stream_dump.sv
// Scoreboard bench for bram_stream_dump: expected addresses and words come from window arithmetic over a random BRAM image.
module tb_bram_stream_dump;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] daddr;
  logic          denb;
  logic [31:0]   din = '0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bram_stream_dump #(.AWIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .daddr     (daddr),
    .denb      (denb),
    .din       (din),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (denb) din <= mem[daddr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  int issued = 0, popped = 0;
  int start_cyc = 0, first_denb = -1, first_valid = -1, done_cyc = -1, done_cnt = 0;
  int rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every issued read and every stream handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("outstanding_le_2", ((issued - popped) <= 2), 1);
      if (denb) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL daddr: got read of %0h expected no read", daddr);
        end else begin
          check("daddr", daddr, exp_addr_q.pop_front());
        end
        issued++;
        if (first_denb < 0) first_denb = cyc - start_cyc;
      end
      if (m_valid && first_valid < 0) first_valid = cyc - start_cyc;
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL m_data: got beat %0h expected no beat", m_data);
        end else begin
          check("m_data", m_data, exp_data_q.pop_front());
        end
        popped++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done && (cyc - start_cyc) >= 1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - start_cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic load_window(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % DEPTH;
      exp_addr_q.push_back(a[AW-1:0]);
      exp_data_q.push_back(mem[a]);
    end
  endtask

  task automatic run_dump(input int b, input int n, input int mode, input bit timing, input bit poke);
    int p0;
    bit got;
    rdy_mode    = mode;
    start_cyc   = cyc;
    first_denb  = -1;
    first_valid = -1;
    done_cyc    = -1;
    done_cnt    = 0;
    p0          = popped;
    got         = 1'b0;
    load_window(b, n);
    start     = 1'b1;
    base_addr = b[AW-1:0];
    count     = n[AW:0];
    for (int k = 0; k < n * 4 + 20; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (poke && k == 4) begin
        start     = 1'b1;
        base_addr = 8'h55;
        count     = 9'd3;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    #1;
    check("beats", popped - p0, n);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("data_q_empty", exp_data_q.size(), 0);
    check("done_pulses", done_cnt, 1);
    if (timing) begin
      check("done_cycle", done_cyc, (n == 0) ? 1 : n + 3);
      check("first_denb_cycle", first_denb, (n == 0) ? -1 : 1);
      check("first_valid_cycle", first_valid, (n == 0) ? -1 : 3);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_daddr"}, daddr, 0);
    check({tag, "_denb"}, denb, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic reset_abort_test();
    int p0;
    bit got;
    rdy_mode   = 0;
    start_cyc  = cyc;
    p0         = popped;
    got        = 1'b0;
    load_window(8'h40, 16);
    start     = 1'b1;
    base_addr = 8'h40;
    count     = 9'd16;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (popped - p0 >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("abort_reached_3_beats", got, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("abort");
    exp_addr_q.delete();
    exp_data_q.delete();
    issued = 0;
    popped = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_abort_denb", denb, 0);
    check("post_abort_valid", m_valid, 0);
    run_dump(8'h20, 2, 0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("idle_denb", denb, 0);
      check("idle_valid", m_valid, 0);
    end

    run_dump(8'h10, 4, 0, 1'b1, 1'b0);
    run_dump(8'h00, 8, 1, 1'b0, 1'b0);
    run_dump(8'hFE, 4, 0, 1'b1, 1'b0);
    run_dump(8'h00, 256, 0, 1'b1, 1'b0);
    run_dump(8'h33, 0, 0, 1'b1, 1'b0);
    run_dump(8'hA0, 16, 2, 1'b0, 1'b1);
    for (int t = 0; t < 10; t++) begin
      run_dump(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)), 2, 1'b0, 1'b0);
    end
    reset_abort_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
